// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised serial sequence detector.
package seq_det_pkg;

  typedef enum logic {FILL, ARMED} state_t;

  localparam logic [5:0] DEFAULT_PAT = 6'b101111;

  // The fill counter must be able to hold the value PAT_W itself.
  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_shift_window.sv
// History shift register plus saturating fill counter. The next-state values are
// exported so the detector can compare against the post-shift window on the same edge.
module seq_shift_window
  import seq_det_pkg::*;
#(
  parameter int HIST_W = 8,
  parameter int PAT_W  = 6,
  parameter int FILL_W = fill_width(PAT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              din,
  input  logic              clear,
  input  logic              restart,
  output logic [HIST_W-1:0] hist,
  output logic [HIST_W-1:0] hist_nxt,
  output logic [FILL_W-1:0] fill_nxt
);

  logic [FILL_W-1:0] fill;

  assign hist_nxt = {hist[HIST_W-2:0], din};
  assign fill_nxt = (fill == FILL_W'(PAT_W)) ? fill : fill + 1'b1;

  // restart zeroes the fill count but keeps the history bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else begin
      if (shift) hist <= hist_nxt;
      if (restart)    fill <= '0;
      else if (shift) fill <= fill_nxt;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial MSB-first pattern detector with run-time loadable pattern, selectable
// overlap mode, registered match pulse and saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W       = 6,
  parameter int               HIST_W      = 8,
  parameter int               CNT_W       = 4,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = seq_det_pkg::DEFAULT_PAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  input  logic              clear,
  input  logic              pat_load,
  input  logic [PAT_W-1:0]  pat_in,
  input  logic              overlap,
  output logic [HIST_W-1:0] hist,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [PAT_W-1:0]  pat_cur
);

  localparam int FILL_W = fill_width(PAT_W);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t            state;
  logic [HIST_W-1:0] hist_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic              shift;
  logic              full;
  logic              hit;
  logic              restart;

  // clear and pat_load both suppress the incoming bit
  assign shift   = din_valid & ~clear & ~pat_load;
  assign full    = (state == ARMED) || (fill_nxt == FILL_W'(PAT_W));
  assign hit     = shift && full && (hist_nxt[PAT_W-1:0] == pat_cur);
  assign restart = pat_load | (hit & ~overlap);

  seq_shift_window #(
    .HIST_W (HIST_W),
    .PAT_W  (PAT_W),
    .FILL_W (FILL_W)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .shift    (shift),
    .din      (din),
    .clear    (clear),
    .restart  (restart),
    .hist     (hist),
    .hist_nxt (hist_nxt),
    .fill_nxt (fill_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      match     <= 1'b0;
      match_cnt <= '0;
      pat_cur   <= DEFAULT_PAT;
    end else if (clear) begin
      state     <= FILL;
      match     <= 1'b0;
      match_cnt <= '0;
    end else if (pat_load) begin
      state   <= FILL;
      match   <= 1'b0;
      pat_cur <= pat_in;
    end else if (din_valid) begin
      match <= hit;
      if (hit) match_cnt <= sat_inc(match_cnt);
      // a non-overlapping hit forces the window to collect PAT_W fresh bits
      if (hit && !overlap) state <= FILL;
      else if (full)       state <= ARMED;
      else                 state <= FILL;
    end else begin
      match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed table, corner sequences and a random
// stream checked against a bit-queue reference model.
module tb_seq_detector_param;

  localparam int PAT_W  = 6;
  localparam int HIST_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              din = 1'b0;
  logic              din_valid = 1'b0;
  logic              clear = 1'b0;
  logic              pat_load = 1'b0;
  logic [PAT_W-1:0]  pat_in = '0;
  logic              overlap = 1'b0;
  logic [HIST_W-1:0] hist;
  logic              match;
  logic [CNT_W-1:0]  match_cnt;
  logic [PAT_W-1:0]  pat_cur;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          q[$];
  int          m_hist;
  int          m_cnt;
  int          m_pat;
  bit          m_match;
  int          pulses;

  typedef struct {
    bit dv;
    bit d;
    bit exp_match;
    int exp_cnt;
    int exp_hist;
  } vec_t;

  vec_t tbl[16];

  seq_detector_param #(
    .PAT_W  (PAT_W),
    .HIST_W (HIST_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .clear     (clear),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .overlap   (overlap),
    .hist      (hist),
    .match     (match),
    .match_cnt (match_cnt),
    .pat_cur   (pat_cur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_hist  = 0;
    m_cnt   = 0;
    m_pat   = 6'b101111;
    m_match = 0;
  endtask

  // Model: a match is the last PAT_W bits collected since the last restart equal the pattern.
  task automatic model_edge(input bit dv, input bit d, input bit clr, input bit ld,
                            input int pin, input bit ov);
    bit hit;
    m_match = 0;
    if (clr) begin
      q.delete();
      m_hist = 0;
      m_cnt  = 0;
    end else if (ld) begin
      m_pat = pin;
      q.delete();
    end else if (dv) begin
      m_hist = ((m_hist << 1) | int'(d)) % (1 << HIST_W);
      q.push_back(d);
      if (q.size() > PAT_W) void'(q.pop_front());
      hit = (q.size() == PAT_W);
      for (int i = 0; i < PAT_W; i++)
        if (q[i] != m_pat[PAT_W-1-i]) hit = 0;
      if (hit) begin
        m_match = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!ov) q.delete();
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".match"}, int'(match), int'(m_match));
    chk({tag, ".cnt"}, int'(match_cnt), m_cnt);
    chk({tag, ".hist"}, int'(hist), m_hist);
    chk({tag, ".pat"}, int'(pat_cur), m_pat);
  endtask

  task automatic step(input string tag, input bit dv, input bit d, input bit clr,
                      input bit ld, input int pin, input bit ov);
    din_valid = dv;
    din       = d;
    clear     = clr;
    pat_load  = ld;
    pat_in    = PAT_W'(pin);
    overlap   = ov;
    @(posedge clk);
    model_edge(dv, d, clr, ld, pin, ov);
    #1;
    if (match) pulses++;
    compare_all(tag);
  endtask

  task automatic send_bits(input string tag, input int bits, input int n, input bit ov);
    for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, bits[i], 1'b0, 1'b0, 0, ov);
  endtask

  initial begin
    model_reset();
    // stream 8'd47 then 8'd46 with the default pattern
    tbl[0]  = '{1, 0, 0, 0, 8'h00}; tbl[1]  = '{1, 0, 0, 0, 8'h00};
    tbl[2]  = '{1, 1, 0, 0, 8'h01}; tbl[3]  = '{1, 0, 0, 0, 8'h02};
    tbl[4]  = '{1, 1, 0, 0, 8'h05}; tbl[5]  = '{1, 1, 0, 0, 8'h0B};
    tbl[6]  = '{1, 1, 0, 0, 8'h17}; tbl[7]  = '{1, 1, 1, 1, 8'h2F};
    tbl[8]  = '{1, 0, 0, 1, 8'h5E}; tbl[9]  = '{1, 0, 0, 1, 8'hBC};
    tbl[10] = '{1, 1, 0, 1, 8'h79}; tbl[11] = '{1, 0, 0, 1, 8'hF2};
    tbl[12] = '{1, 1, 0, 1, 8'hE5}; tbl[13] = '{1, 1, 0, 1, 8'hCB};
    tbl[14] = '{1, 1, 0, 1, 8'h97}; tbl[15] = '{1, 0, 0, 1, 8'h2E};

    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    chk("reset.pat_const", int'(pat_cur), 6'b101111);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step("tbl", tbl[i].dv, tbl[i].d, 1'b0, 1'b0, 0, 1'b0);
      chk("tbl.match", int'(match), int'(tbl[i].exp_match));
      chk("tbl.cnt", int'(match_cnt), tbl[i].exp_cnt);
      chk("tbl.hist", int'(hist), tbl[i].exp_hist);
    end

    // overlapping detection on 10101010
    step("ov.clr", 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    step("ov.ld", 1'b0, 1'b0, 1'b0, 1'b1, 6'b101010, 1'b1);
    pulses = 0;
    send_bits("ov", 8'b10101010, 8, 1'b1);
    chk("ov.pulses", pulses, 2);
    chk("ov.cnt_final", int'(match_cnt), 2);

    // same stream non-overlapping
    step("nov.clr", 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    pulses = 0;
    send_bits("nov", 8'b10101010, 8, 1'b0);
    chk("nov.pulses", pulses, 1);
    chk("nov.cnt_final", int'(match_cnt), 1);

    // counter saturation with 22 ones
    step("sat.clr", 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    step("sat.ld", 1'b0, 1'b0, 1'b0, 1'b1, 6'b111111, 1'b1);
    pulses = 0;
    for (int i = 0; i < 22; i++) step("sat", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    chk("sat.pulses", pulses, 17);
    chk("sat.cnt_final", int'(match_cnt), 15);

    // asynchronous reset in the middle of a partial sequence
    send_bits("rstmid", 5'b10111, 5, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all("rstmid.async");
    #1 rst = 1'b1;
    step("rstmid.after", 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    chk("rstmid.hist", int'(hist), 8'h01);
    chk("rstmid.pat", int'(pat_cur), 6'b101111);

    // priority: clear beats pat_load beats din_valid
    send_bits("pri.pre", 3'b101, 3, 1'b0);
    step("pri.all", 1'b1, 1'b1, 1'b1, 1'b1, 6'b010101, 1'b0);
    chk("pri.cnt", int'(match_cnt), 0);
    chk("pri.pat_kept", int'(pat_cur), 6'b101111);
    chk("pri.no_shift", int'(hist), 0);
    send_bits("pri.mid", 5'b11011, 5, 1'b0);
    step("pri.ld", 1'b1, 1'b1, 1'b0, 1'b1, 6'b110110, 1'b0);
    chk("pri.loaded", int'(pat_cur), 6'b110110);
    chk("pri.bit_ignored", int'(hist), 8'h1B);
    pulses = 0;
    send_bits("pri.fill", 1'b0, 1, 1'b0);
    chk("pri.fill_restart", pulses, 0);

    // valid gaps inside 101111
    step("gap.clr", 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    step("gap.ld", 1'b0, 1'b0, 1'b0, 1'b1, 6'b101111, 1'b0);
    pulses = 0;
    send_bits("gap.a", 3'b101, 3, 1'b0);
    for (int i = 0; i < 3; i++) step("gap.idle", 1'b0, 1'($urandom_range(1)), 1'b0, 1'b0, 0, 1'b0);
    send_bits("gap.b", 3'b111, 3, 1'b0);
    chk("gap.pulses", pulses, 1);
    chk("gap.match_last", int'(match), 1);

    // random stream
    for (int i = 0; i < 2000; i++) begin
      int r;
      int pin;
      r = int'($urandom_range(99));
      case ($urandom_range(3))
        0: pin = 6'b101111;
        1: pin = 6'b111111;
        2: pin = 6'b101010;
        default: pin = int'($urandom_range(63));
      endcase
      step("rnd", r < 75, 1'($urandom_range(1)), r == 99, r >= 96 && r < 99, pin,
           1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial sequence detector, successor to the fixed 8-bit "101111" shift-register detector in the Sequence Detector lab. Bits arrive MSB-first on a qualified serial input; a PAT_W-bit pattern, loadable at run time, is compared against the most recent bits. Overlapping or non-overlapping detection is selectable. The block emits a one-cycle match pulse, keeps a saturating match count and exposes the history window to the board LEDs.

## Interface
- PAT_W, 6, pattern length in bits (2..16).
- HIST_W, 8, width of the history window output (≥ PAT_W).
- CNT_W, 4, width of the saturating match counter.
- DEFAULT_PAT, 6'b101111, pattern value after reset.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled on this edge when high.
- clear  in  1  synchronous clear of history, fill state and counter.
- pat_load  in  1  load pat_in as the new pattern on this edge.
- pat_in  in  PAT_W  new pattern; MSB is the first bit of the sequence.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- hist  out  HIST_W  shift window; LSB is the newest bit.
- match  out  1  one-cycle detection pulse.
- match_cnt  out  CNT_W  saturating count of matches.
- pat_cur  out  PAT_W  currently active pattern.

## Operation
- Reset (rst low, async): hist=0, match=0, match_cnt=0, pat_cur=DEFAULT_PAT, fill=0, state=FILL.
- FSM states:
  - FILL: fewer than PAT_W valid bits are held since the last reset, clear, load or non-overlap match.
  - ARMED: the window holds at least PAT_W valid bits.
- The fill counter saturates at PAT_W. FILL→ARMED on the valid bit that brings fill to PAT_W.
- Shift on din_valid: hist ← {hist[HIST_W-2:0], din}. The fill counter increments toward PAT_W.
- Match condition: the post-shift hist[PAT_W-1:0] == pat_cur AND the post-shift fill == PAT_W.
- On a match:
  - match=1 for that cycle.
  - match_cnt increments; it saturates at 2^CNT_W−1.
  - overlap=0: fill←0 and the FSM goes to FILL. hist is kept, but the next match needs PAT_W fresh bits.
  - overlap=1: the FSM stays ARMED.
- pat_load: pat_cur←pat_in, fill←0, state FILL. hist and match_cnt are kept. din is ignored that cycle.
- clear: hist, fill, match_cnt and match go to 0, state FILL. pat_cur is kept.
- Priority of simultaneous events: rst > clear > pat_load > din_valid.
- din_valid low: no shift, match=0, all other state held.
- overlap is sampled every cycle. Changing it mid-stream affects only subsequent matches.

## Timing
- Match latency: match is registered and high in the cycle directly after the rising edge that samples the completing bit. It is never high for two consecutive cycles unless two consecutive valid bits both complete a match (overlap=1).
- match_cnt and hist update on the same edge as match.
- Back-to-back din_valid is supported at one bit per cycle.
- pat_load takes effect on the next edge. The first possible match is PAT_W valid bits later.
- An asynchronous rst assertion mid-sequence discards the partial sequence immediately. The outputs take their reset values without waiting for clk.

## Structure
- Package seq_det_pkg:
  - state enum {FILL, ARMED}.
  - DEFAULT_PAT constant.
  - function to compute the fill-counter width ($clog2(PAT_W+1)).
- Sub-module seq_shift_window: the HIST_W shift register plus the fill counter with load/clear inputs.
- Top level: the compare logic, the FSM, the match register and the saturating counter.

## Test plan
- Defaults: stream 8'd47 (00101111) MSB-first → one match pulse after bit 8, match_cnt=1, hist=8'h2F. Then stream 8'd46 → no match, match_cnt stays 1.
- Overlap: pat_load 6'b101010, overlap=1, stream 10101010 → matches after bits 6 and 8, match_cnt=2. Repeat after clear with overlap=0 → only the match after bit 6, match_cnt=1.
- Saturation: CNT_W=4, overlap=1, pattern 6'b111111, stream 22 ones → 17 match pulses, match_cnt holds at 15.
- Reset mid-sequence: send 10111 of 101111, pulse rst low between edges, then send 1 → no match, hist=8'h01, pattern back to 101111.
- Priority: assert clear, pat_load and din_valid together → counter 0, pat_cur unchanged, no shift. Then pat_load with din_valid → pattern loaded, bit ignored, fill=0.
- din_valid gaps: send 101111 with din_valid low for 3 cycles between bits 3 and 4 → a single match after the 6th valid bit, with no spurious pulses in the gaps.
